// File: rtl/text_overlay_pkg.sv
// Shared types, control codes and row arithmetic for the text overlay.
package text_overlay_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StClrRow
  } state_e;

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  // (a + b) mod rows, for a, b < rows <= 64.
  function automatic logic [5:0] row_wrap_add(input logic [5:0]  a,
                                              input logic [5:0]  b,
                                              input int unsigned rows);
    logic [6:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 7'(rows)) begin
      sum = sum - 7'(rows);
    end
    return sum[5:0];
  endfunction

endpackage

// File: rtl/text_overlay_ram.sv
// Character RAM: one write port, one registered read port, no reset on the array.
module text_overlay_ram #(
  parameter int unsigned Depth = 2048,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [Depth];
  logic [7:0] rdata_q;

  // Read returns the pre-write contents on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_overlay.sv
// Character-cell text overlay: terminal-style cursor FSM filling a character RAM,
// and a two-stage display pipeline turning font-engine coordinates into pixels.
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int unsigned Cols      = 64,
  parameter int unsigned Rows      = 32,
  parameter logic [7:0]  BlankCode = 8'h20
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [7:0]   char_x_i,
  input  logic [7:0]   char_y_i,
  input  logic [255:0] ascii_char_i,
  input  logic         blank_i,
  input  logic         wr_valid_i,
  input  logic [7:0]   wr_data_i,
  output logic         wr_ready_o,
  output logic         busy_o,
  output logic [7:0]   cursor_x_o,
  output logic [5:0]   cursor_y_o,
  output logic         pixel_o
);

  localparam int unsigned Cells = Cols * Rows;
  localparam int unsigned AddrW = $clog2(Cells);

  function automatic logic [AddrW-1:0] cell_addr(input logic [5:0] row, input logic [7:0] col);
    return AddrW'(32'(row) * Cols + 32'(col));
  endfunction

  state_e           state_q, state_d;
  logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;
  logic [7:0]       cur_x_q, cur_x_d;
  logic [5:0]       cur_y_q, cur_y_d;
  logic [5:0]       top_q, top_d;

  logic             ram_we;
  logic [AddrW-1:0] ram_waddr;
  logic [7:0]       ram_wdata;
  logic [AddrW-1:0] ram_raddr;
  logic [7:0]       ram_rdata;

  // Display pipeline.
  logic       in_range;
  logic [5:0] disp_row;
  logic       vis_q;
  logic       pixel_q;

  assign in_range  = ({1'b0, char_x_i} < 9'(Cols)) && ({1'b0, char_y_i} < 9'(Rows));
  assign disp_row  = row_wrap_add(char_y_i[5:0], top_q, Rows);
  assign ram_raddr = cell_addr(disp_row, char_x_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vis_q   <= 1'b0;
      pixel_q <= 1'b0;
    end else begin
      vis_q   <= in_range & ~blank_i;
      pixel_q <= vis_q & ascii_char_i[ram_rdata];
    end
  end

  // Cursor FSM.
  logic       advance;
  logic [5:0] bottom_row;

  assign bottom_row = row_wrap_add(top_q, 6'(Rows - 1), Rows);

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    top_d      = top_q;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    ram_wdata  = BlankCode;
    wr_ready_o = 1'b0;
    advance    = 1'b0;

    unique case (state_q)
      StClear: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        if (clr_cnt_q == AddrW'(Cells - 1)) begin
          clr_cnt_d = '0;
          cur_x_d   = '0;
          cur_y_d   = '0;
          top_d     = '0;
          state_d   = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StClrRow: begin
        ram_we    = 1'b1;
        ram_waddr = cell_addr(bottom_row, 8'(clr_cnt_q));
        if (clr_cnt_q == AddrW'(Cols - 1)) begin
          clr_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        wr_ready_o = 1'b1;
        if (wr_valid_i) begin
          unique case (wr_data_i)
            CHR_FF: begin
              clr_cnt_d = '0;
              state_d   = StClear;
            end
            CHR_CR: cur_x_d = '0;
            CHR_BS: begin
              if (cur_x_q != '0) begin
                cur_x_d = cur_x_q - 1'b1;
              end
            end
            CHR_LF: begin
              cur_x_d = '0;
              advance = 1'b1;
            end
            default: begin
              ram_we    = 1'b1;
              ram_waddr = cell_addr(row_wrap_add(cur_y_q, top_q, Rows), cur_x_q);
              ram_wdata = wr_data_i;
              if ({1'b0, cur_x_q} + 9'd1 == 9'(Cols)) begin
                cur_x_d = '0;
                advance = 1'b1;
              end else begin
                cur_x_d = cur_x_q + 1'b1;
              end
            end
          endcase
        end
      end
    endcase

    // On the last row the screen scrolls: the old top line becomes the new bottom.
    if (advance) begin
      if (cur_y_q < 6'(Rows - 1)) begin
        cur_y_d = cur_y_q + 1'b1;
      end else begin
        top_d     = row_wrap_add(top_q, 6'd1, Rows);
        clr_cnt_d = '0;
        state_d   = StClrRow;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      top_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      top_q     <= top_d;
    end
  end

  text_overlay_ram #(
    .Depth(Cells),
    .AddrW(AddrW)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  assign busy_o     = (state_q != StIdle);
  assign cursor_x_o = cur_x_q;
  assign cursor_y_o = cur_y_q;
  assign pixel_o    = pixel_q;

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: pixel probes go through a scoreboard queue checked by a monitor.
module tb_text_overlay;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   char_x = '0;
  logic [7:0]   char_y = '0;
  logic [255:0] ascii = '0;
  logic         blank = 1'b0;
  logic         wr_valid = 1'b0;
  logic [7:0]   wr_data = '0;
  logic         wr_ready;
  logic         busy;
  logic [7:0]   cur_x;
  logic [5:0]   cur_y;
  logic         pixel;

  always #5 clk = ~clk;

  text_overlay #(
    .Cols(64),
    .Rows(32),
    .BlankCode(8'h20)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .char_x_i    (char_x),
    .char_y_i    (char_y),
    .ascii_char_i(ascii),
    .blank_i     (blank),
    .wr_valid_i  (wr_valid),
    .wr_data_i   (wr_data),
    .wr_ready_o  (wr_ready),
    .busy_o      (busy),
    .cursor_x_o  (cur_x),
    .cursor_y_o  (cur_y),
    .pixel_o     (pixel)
  );

  typedef struct {
    logic exp;
    int   x;
    int   y;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_err = 0;
  logic [255:0] glyph_next = '0;
  logic         probe_v = 1'b0;
  logic         p1 = 1'b0;
  logic         p2 = 1'b0;

  // The glyph vector lags the coordinates by one cycle; the probe tag lags two.
  always @(posedge clk) begin
    ascii <= glyph_next;
    p1    <= probe_v;
    p2    <= p1;
  end

  always @(negedge clk) begin
    if (p2) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pixel: unexpected sample %0b, none required", pixel);
      end else begin
        mon_e = sb.pop_front();
        if (pixel !== mon_e.exp) begin
          n_err++;
          $display("FAIL pixel(%0d,%0d): got %0b required %0b", mon_e.x, mon_e.y, pixel, mon_e.exp);
        end
      end
    end
  end

  function automatic logic [255:0] only(input int code);
    logic [255:0] g;
    g = '0;
    g[code] = 1'b1;
    return g;
  endfunction

  function automatic logic [255:0] all_but(input int code);
    logic [255:0] g;
    g = '1;
    g[code] = 1'b0;
    return g;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the next posedge.
  task automatic probe(input int x, input int y, input logic bl, input logic [255:0] g,
                       input logic exp);
    char_x     = 8'(x);
    char_y     = 8'(y);
    blank      = bl;
    glyph_next = g;
    probe_v    = 1'b1;
    sb.push_back('{exp, x, y});
    @(posedge clk);
    #1;
    probe_v = 1'b0;
    blank   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d pixel samples outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    while (!wr_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL send: byte %02h not accepted, wr_ready %0b required 1", b, wr_ready);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  // Counts consecutive cycles with wr_ready low, starting at the current cycle.
  task automatic count_busy(input string nm, input int exp);
    int n = 0;
    @(negedge clk);
    while (!wr_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check(nm, n, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cursor(input string nm, input int x, input int y);
    check({nm, " cursor_x"}, int'(cur_x), x);
    check({nm, " cursor_y"}, int'(cur_y), y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release and initial clear.
    @(posedge clk);
    #1;
    check("reset pixel", int'(pixel), 0);
    check("reset wr_ready", int'(wr_ready), 0);
    check("reset busy", int'(busy), 1);
    rst_n = 1'b1;
    count_busy("initial clear length", 2048);
    check_cursor("after clear", 0, 0);
    check("idle busy", int'(busy), 0);
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 64; x++) begin
        probe(x, y, 1'b0, all_but(8'h20), 1'b0);
      end
    end
    drain();

    // Backspace at column 0.
    send(8'h08);
    check_cursor("bs at col0", 0, 0);

    // Text render.
    send(8'h41);
    send(8'h42);
    check_cursor("AB", 2, 0);
    probe(0, 0, 1'b0, only(8'h41), 1'b1);
    probe(0, 0, 1'b0, '0, 1'b0);
    probe(1, 0, 1'b0, only(8'h41), 1'b0);
    probe(1, 0, 1'b0, only(8'h42), 1'b1);
    probe(2, 0, 1'b0, only(8'h20), 1'b1);
    drain();

    // CR, Q, BS.
    send(8'h0D);
    check_cursor("cr", 0, 0);
    send(8'h51);
    check_cursor("Q", 1, 0);
    send(8'h08);
    check_cursor("Q bs", 0, 0);
    probe(0, 0, 1'b0, only(8'h51), 1'b1);
    drain();

    // Line wrap.
    for (int i = 0; i < 64; i++) send(8'h58);
    check_cursor("wrap", 0, 1);
    probe(63, 0, 1'b0, only(8'h58), 1'b1);
    probe(0, 0, 1'b0, only(8'h58), 1'b1);
    probe(0, 1, 1'b0, only(8'h58), 1'b0);
    drain();

    // CR mid-line keeps the row.
    send(8'h45);
    check_cursor("E", 1, 1);
    send(8'h0D);
    check_cursor("cr midline", 0, 1);

    // Form feed clears the screen.
    send(8'h0C);
    count_busy("ff clear length", 2048);
    check_cursor("after ff", 0, 0);
    probe(0, 0, 1'b0, all_but(8'h20), 1'b0);
    probe(63, 0, 1'b0, all_but(8'h20), 1'b0);
    probe(0, 1, 1'b0, only(8'h20), 1'b1);
    drain();

    // Scroll.
    for (int i = 0; i < 31; i++) send(8'h0A);
    check_cursor("31 lf", 0, 31);
    check("31 lf busy", int'(busy), 0);
    send(8'h5A);
    check_cursor("Z", 1, 31);
    send(8'h0A);
    count_busy("clr_row length", 64);
    check_cursor("after scroll", 0, 31);
    probe(0, 30, 1'b0, only(8'h5A), 1'b1);
    probe(1, 30, 1'b0, only(8'h20), 1'b1);
    probe(0, 31, 1'b0, only(8'h20), 1'b1);
    probe(0, 31, 1'b0, all_but(8'h20), 1'b0);
    probe(63, 31, 1'b0, all_but(8'h20), 1'b0);

    // Range and blanking.
    probe(64, 29, 1'b0, '1, 1'b0);
    probe(0, 32, 1'b0, '1, 1'b0);
    probe(0, 30, 1'b1, '1, 1'b0);
    probe(0, 30, 1'b0, '1, 1'b1);
    drain();

    // Reset in the middle of a row clear restarts a full clear.
    send(8'h0A);
    repeat (10) @(posedge clk);
    #1;
    check("mid clr_row wr_ready", int'(wr_ready), 0);
    check("mid clr_row busy", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_busy("reclear length", 2048);
    check_cursor("after reclear", 0, 0);
    probe(0, 31, 1'b0, all_but(8'h20), 1'b0);
    probe(0, 30, 1'b0, all_but(8'h20), 1'b0);
    probe(5, 0, 1'b0, only(8'h20), 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
